// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin owner of the single VGA pixel-write port shared
// by four drawing engines, with a hold watchdog and on-screen clipping.
module vga_draw_arbiter #(
   parameter int unsigned NUM_REQ         = 4,
   parameter logic [15:0] MAX_HOLD        = 16'd20000,
   parameter logic [7:0]  X_SCREEN_PIXELS = 8'd160,
   parameter logic [6:0]  Y_SCREEN_PIXELS = 7'd120
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   done,
   input  logic [NUM_REQ-1:0]   wr_en,
   input  logic [8*NUM_REQ-1:0] x_in,
   input  logic [7*NUM_REQ-1:0] y_in,
   input  logic [3*NUM_REQ-1:0] colour_in,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic [7:0]           vga_x,
   output logic [6:0]           vga_y,
   output logic [2:0]           vga_colour,
   output logic                 vga_plot,
   output logic                 timeout_err
);

   localparam int unsigned SEL_W  = 2;
   localparam int unsigned XW     = 8;
   localparam int unsigned YW     = 7;
   localparam int unsigned CW     = 3;
   localparam int unsigned HOLD_W = 16;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic                busy_q, busy_d;
   logic [XW-1:0]       vga_x_q, vga_x_d;
   logic [YW-1:0]       vga_y_q, vga_y_d;
   logic [CW-1:0]       vga_colour_q, vga_colour_d;
   logic                vga_plot_q, vga_plot_d;
   logic                timeout_q, timeout_d;

   logic [SEL_W-1:0]    win_c;
   logic                found_c;
   logic [XW-1:0]       sel_x_c;
   logic [YW-1:0]       sel_y_c;
   logic [CW-1:0]       sel_colour_c;
   logic                end_c;
   logic                hold_hit_c;

   // First set request at or after rr_ptr, wrapping; descending scan keeps the nearest.
   always_comb begin
      win_c   = rr_ptr_q;
      found_c = 1'b0;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         if (req[SEL_W'(rr_ptr_q + SEL_W'(k))]) begin
            win_c   = SEL_W'(rr_ptr_q + SEL_W'(k));
            found_c = 1'b1;
         end
      end
   end

   assign sel_x_c      = x_in[XW*sel_q +: XW];
   assign sel_y_c      = y_in[YW*sel_q +: YW];
   assign sel_colour_c = colour_in[CW*sel_q +: CW];
   assign end_c        = done[sel_q] | ~req[sel_q];
   assign hold_hit_c   = (hold_q == HOLD_W'(MAX_HOLD - 16'd1));

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      rr_ptr_d     = rr_ptr_q;
      hold_d       = hold_q;
      grant_d      = grant_q;
      busy_d       = busy_q;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      vga_plot_d   = 1'b0;
      timeout_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found_c) begin
               state_d = S_GRANT;
               sel_d   = win_c;
               grant_d = NUM_REQ'(1) << win_c;
               busy_d  = 1'b1;
               hold_d  = '0;
            end
         end
         S_GRANT: begin
            hold_d = hold_q + HOLD_W'(1);
            // A strobe coinciding with done is still issued.
            if (wr_en[sel_q]) begin
               vga_x_d      = sel_x_c;
               vga_y_d      = sel_y_c;
               vga_colour_d = sel_colour_c;
               vga_plot_d   = (sel_x_c < X_SCREEN_PIXELS) && (sel_y_c < Y_SCREEN_PIXELS);
            end
            if (end_c || hold_hit_c) begin
               state_d   = S_RELEASE;
               grant_d   = '0;
               busy_d    = 1'b0;
               rr_ptr_d  = SEL_W'(sel_q + SEL_W'(1));
               timeout_d = hold_hit_c & ~end_c;
            end
         end
         S_RELEASE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         sel_q        <= '0;
         rr_ptr_q     <= '0;
         hold_q       <= '0;
         grant_q      <= '0;
         busy_q       <= 1'b0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         rr_ptr_q     <= rr_ptr_d;
         hold_q       <= hold_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_plot_q   <= vga_plot_d;
         timeout_q    <= timeout_d;
      end
   end

   assign grant       = grant_q;
   assign busy        = busy_q;
   assign vga_x       = vga_x_q;
   assign vga_y       = vga_y_q;
   assign vga_colour  = vga_colour_q;
   assign vga_plot    = vga_plot_q;
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: directed scenarios plus random traffic, each cycle
// compared against a transaction-level ownership model of the arbiter.
module tb_vga_draw_arbiter;

   localparam logic [15:0] HOLD = 16'd8;

   logic        clk = 1'b0;
   logic        resetn;
   logic [3:0]  req, done, wr_en;
   logic [31:0] x_in;
   logic [27:0] y_in;
   logic [11:0] colour_in;
   logic [3:0]  grant;
   logic        busy;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic        timeout_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vga_draw_arbiter #(
      .NUM_REQ        (4),
      .MAX_HOLD       (HOLD),
      .X_SCREEN_PIXELS(8'd160),
      .Y_SCREEN_PIXELS(7'd120)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req        (req),
      .done       (done),
      .wr_en      (wr_en),
      .x_in       (x_in),
      .y_in       (y_in),
      .colour_in  (colour_in),
      .grant      (grant),
      .busy       (busy),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .timeout_err(timeout_err)
   );

   // Reference: who owns the port, how long it has held it, where the search starts.
   int         m_owner, m_dead, m_start, m_held;
   logic       m_plot, m_to;
   logic [7:0] m_x;
   logic [6:0] m_y;
   logic [2:0] m_c;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_dead = 0; m_start = 0; m_held = 0;
      m_plot = 1'b0; m_to = 1'b0; m_x = '0; m_y = '0; m_c = '0;
   endtask

   task automatic model_step();
      m_plot = 1'b0;
      m_to   = 1'b0;
      if (m_owner >= 0) begin
         int o;
         bit fin;
         o = m_owner;
         m_held++;
         if (wr_en[o]) begin
            m_x    = x_in[8*o +: 8];
            m_y    = y_in[7*o +: 7];
            m_c    = colour_in[3*o +: 3];
            m_plot = (int'(m_x) < 160) && (int'(m_y) < 120);
         end
         fin = done[o] || !req[o];
         if (fin || m_held == int'(HOLD)) begin
            m_to    = !fin;
            m_start = (o + 1) % 4;
            m_owner = -1;
            m_dead  = 1;
         end
      end else if (m_dead > 0) begin
         m_dead--;
      end else if (req != 4'b0) begin
         for (int i = 0; i < 4; i++) begin
            if (req[(m_start + i) % 4]) begin
               m_owner = (m_start + i) % 4;
               break;
            end
         end
         m_held = 0;
      end
   endtask

   task automatic check_all();
      chk("grant",   32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("busy",    32'(busy), 32'(m_owner >= 0));
      chk("plot",    32'(vga_plot), 32'(m_plot));
      chk("timeout", 32'(timeout_err), 32'(m_to));
      chk("pixel",   32'({vga_x, vga_y, vga_colour}), 32'({m_x, m_y, m_c}));
   endtask

   // Called one time unit after a rising edge: drive, clock, model, compare.
   task automatic cyc(input logic [3:0] r, input logic [3:0] d, input logic [3:0] w,
                      input logic [31:0] x, input logic [27:0] y, input logic [11:0] c);
      req = r; done = d; wr_en = w; x_in = x; y_in = y; colour_in = c;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic drain();
      for (int n = 0; n < 8 && (m_owner >= 0 || m_dead > 0); n++)
         cyc(4'b0, 4'b0, 4'b0, 32'b0, 28'b0, 12'b0);
      cyc(4'b0, 4'b0, 4'b0, 32'b0, 28'b0, 12'b0);
   endtask

   function automatic logic [31:0] lx(input int i, input logic [7:0] v);
      logic [31:0] r;
      r = $urandom;
      r[8*i +: 8] = v;
      return r;
   endfunction

   function automatic logic [27:0] ly(input int i, input logic [6:0] v);
      logic [27:0] r;
      r = 28'($urandom);
      r[7*i +: 7] = v;
      return r;
   endfunction

   function automatic logic [11:0] lc(input int i, input logic [2:0] v);
      logic [11:0] r;
      r = 12'($urandom);
      r[3*i +: 3] = v;
      return r;
   endfunction

   initial begin
      logic [3:0]  d, r;
      logic [3:0]  prev;
      logic [31:0] order[$];
      int          gaps[$];
      int          gap, g1_cycles, n_to;
      bit          saw_g2;
      logic [7:0]  bx[3];
      logic [6:0]  by[3];
      logic        bp[3];

      req = '0; done = '0; wr_en = '0; x_in = '0; y_in = '0; colour_in = '0;
      resetn = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      resetn = 1'b1;

      // Round robin with every engine requesting, two-cycle bursts.
      prev = '0; gap = 0;
      for (int n = 0; n < 40 && order.size() < 5; n++) begin
         d = '0;
         if (m_owner >= 0 && m_held == 1) d[m_owner] = 1'b1;
         cyc(4'hF, d, 4'h0, 32'b0, 28'b0, 12'b0);
         if (grant != 4'b0 && prev == 4'b0) begin
            order.push_back(32'(grant));
            gaps.push_back(gap);
         end
         gap  = (grant == 4'b0) ? gap + 1 : 0;
         prev = grant;
      end
      chk("rr_count", 32'(order.size()), 32'd5);
      if (order.size() == 5) begin
         chk("rr_order0", order[0], 32'h1);
         chk("rr_order1", order[1], 32'h2);
         chk("rr_order2", order[2], 32'h4);
         chk("rr_order3", order[3], 32'h8);
         chk("rr_order4", order[4], 32'h1);
         for (int i = 1; i < 5; i++) chk("rr_gap", 32'(gaps[i]), 32'd2);
      end
      drain();

      // Single requester 2: three strobes then done.
      cyc(4'b0100, 4'b0, 4'b0, 32'b0, 28'b0, 12'b0);
      chk("single_grant", 32'(grant), 32'h4);
      for (int k = 0; k < 3; k++) begin
         cyc(4'b0100, 4'b0, 4'b0100, lx(2, 8'(10 + k)), ly(2, 7'd20), lc(2, 3'b010));
         chk("single_plot", 32'(vga_plot), 32'd1);
         chk("single_xyc", 32'({vga_x, vga_y, vga_colour}), 32'({8'(10 + k), 7'd20, 3'b010}));
      end
      cyc(4'b0100, 4'b0100, 4'b0, 32'b0, 28'b0, 12'b0);
      chk("single_release", 32'(grant), 32'h0);
      drain();

      // Clipping on requester 3; pointer now at 3 so it wins at once.
      bx[0] = 8'd159; by[0] = 7'd119; bp[0] = 1'b1;
      bx[1] = 8'd160; by[1] = 7'd5;   bp[1] = 1'b0;
      bx[2] = 8'd3;   by[2] = 7'd120; bp[2] = 1'b0;
      cyc(4'b1001, 4'b0, 4'b0, 32'b0, 28'b0, 12'b0);
      chk("rr_after_single", 32'(grant), 32'h8);
      for (int k = 0; k < 3; k++) begin
         cyc(4'b1000, 4'b0, 4'b1000, lx(3, bx[k]), ly(3, by[k]), lc(3, 3'b111));
         chk("bounds_plot", 32'(vga_plot), 32'(bp[k]));
      end
      cyc(4'b1000, 4'b1000, 4'b0, 32'b0, 28'b0, 12'b0);
      drain();

      // Isolation: requester 1 strobes while 0 owns the port; stray done[1] ignored.
      cyc(4'b0001, 4'b0, 4'b0, 32'b0, 28'b0, 12'b0);
      cyc(4'b0001, 4'b0010, 4'b0010, lx(1, 8'd50), ly(1, 7'd1), lc(1, 3'b001));
      chk("iso_plot", 32'(vga_plot), 32'd0);
      chk("iso_x", 32'(vga_x), 32'd3);
      chk("iso_grant", 32'(grant), 32'h1);
      cyc(4'b0001, 4'b0001, 4'b0, 32'b0, 28'b0, 12'b0);
      drain();

      // Watchdog: requester 1 never finishes, requester 2 waits behind it.
      g1_cycles = 0; n_to = 0; saw_g2 = 1'b0;
      for (int n = 0; n < 14; n++) begin
         cyc(4'b0110, 4'b0, 4'b0, 32'b0, 28'b0, 12'b0);
         if (grant[1]) g1_cycles++;
         if (timeout_err) n_to++;
         if (grant == 4'b0100 && g1_cycles > 0) saw_g2 = 1'b1;
      end
      chk("wd_hold", 32'(g1_cycles), 32'(HOLD));
      chk("wd_pulses", 32'(n_to), 32'd1);
      chk("wd_next", 32'(saw_g2), 32'd1);
      drain();

      // Reset mid-burst, then the search must restart from requester 0.
      cyc(4'b0001, 4'b0, 4'b0, 32'b0, 28'b0, 12'b0);
      cyc(4'b0001, 4'b0, 4'b0001, lx(0, 8'd7), ly(0, 7'd8), lc(0, 3'b101));
      cyc(4'b0001, 4'b0, 4'b0001, lx(0, 8'd9), ly(0, 7'd8), lc(0, 3'b101));
      #3;
      resetn = 1'b0;
      #1;
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_plot",  32'(vga_plot), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      cyc(4'hF, 4'b0, 4'b0, 32'b0, 28'b0, 12'b0);
      chk("rst_restart", 32'(grant), 32'h1);
      drain();

      // Random traffic: level requests that toggle, stray done/strobe on every lane.
      r = '0;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(7) == 0) r[i] = ~r[i];
         for (int i = 0; i < 4; i++) d[i] = ($urandom_range(5) == 0);
         cyc(r, d, 4'($urandom), $urandom, 28'($urandom), 12'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
